roulette_spin_ctrl: RTL and testbench
=====================================

Name: roulette_spin_ctrl

Overview:
Sequences the roulette wheel sprite animation. On a spin request it steps a pocket index at frame rate, first at constant speed and then decelerating. It drives the sprite ROM base address so the pixel fetch path shows the current wheel frame. When the wheel stops it reports the pocket as the game result. It sits between game logic and the sprite ROM/palette drawing path in the vga_clk domain.

Parameters:
NUM_POCKETS, 37, number of wheel pockets/frames; pocket index wraps NUM_POCKETS-1 -> 0
FRAME_PIXELS, 4096, ROM words per frame; rom_base = pocket_idx * FRAME_PIXELS
ADDR_W, 19, rom_base width
BASE_STEPS, 40, minimum constant-speed advances per spin
INIT_DELAY, 1, frame ticks per advance during cruise and at decel start
MAX_DELAY, 8, slowest delay; wheel stops after finishing this delay level
STEPS_PER_SLOW, 4, advances performed at each delay level during decel

Ports:
vga_clk  in  1  sole clock
Reset  in  1  synchronous, active-high reset
frame_tick  in  1  one-cycle pulse per video frame (vsync-derived)
spin_req  in  1  one-cycle spin request
busy  out  1  high from spin accept until the result_valid cycle, inclusive
pocket_idx  out  6  current displayed pocket
rom_base  out  ADDR_W  sprite ROM base address of the current frame
result_valid  out  1  one-cycle pulse when the wheel stops
result  out  6  final pocket, held until the next result

Behaviour:
- Reset (synchronous): state IDLE; busy=0, pocket_idx=0, rom_base=0, result_valid=0, result=0; lfsr=16'hACE1; all counters 0.
- LFSR: 16-bit, advances every cycle, including in IDLE. lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
- IDLE:
  - spin_req=1 -> CRUISE.
  - Load cruise_cnt = BASE_STEPS + lfsr[5:0], using the value present in that cycle.
  - Load delay=INIT_DELAY, frame_cnt=0, slow_cnt=0.
  - busy goes to 1 on the next cycle.
  - A frame_tick in the accept cycle is not counted.
- Advance event: on a frame_tick where frame_cnt==delay-1.
  - pocket_idx increments, with wrap.
  - frame_cnt resets to 0.
  - Other frame_ticks only increment frame_cnt.
- CRUISE:
  - Each advance decrements cruise_cnt.
  - The advance that takes cruise_cnt to 0 -> DECEL, with delay unchanged and slow_cnt=0.
- DECEL:
  - Each advance increments slow_cnt.
  - When slow_cnt reaches STEPS_PER_SLOW: slow_cnt=0.
  - If delay==MAX_DELAY -> DONE; otherwise delay++.
- DONE (one cycle): result_valid=1, result=pocket_idx, busy=1 -> IDLE.
- rom_base is registered, one cycle after pocket_idx changes. pocket_idx only changes on frame_tick cycles, so the base never changes mid-frame.
- spin_req while busy is ignored and not queued.
- Reset mid-spin aborts immediately to reset values. No result_valid is emitted.
- Total advances per spin = cruise_cnt + (MAX_DELAY-INIT_DELAY+1)*STEPS_PER_SLOW. Each spin starts from the previous stop position.

Optional Feature:
SPIN_SKIP_EN:
- Defined: adds input port skip (1 bit).
- skip=1 in CRUISE or DECEL -> DONE next cycle; result = current pocket_idx.
- skip is ignored in IDLE/DONE.
- Skip takes priority over a simultaneous advance; that advance is dropped.
- Undefined: no skip port; the full sequence always runs.

Test Plan:
- Reset, then spin_req in the first cycle after Reset deasserts (lfsr=ACE1, lfsr[5:0]=33), frame_tick every 10 cycles:
  - cruise_cnt=73, decel advances=32, 105 advances in total.
  - result_valid after 217 frame_ticks; result=31, rom_base=0x1F000.
- During the spin above, pulse spin_req mid-cruise -> ignored; result and timing are unchanged.
- Second spin right after the first:
  - Starts from pocket 31.
  - Pocket stepping wraps from 36 to 0.
  - Final result = (31 + advances) mod 37.
- Decel delay check:
  - Measure frame_ticks between advances: 1 during cruise, then 1,2,...,8, each for 4 advances.
  - busy drops the cycle after result_valid.
- Assert Reset mid-decel -> next cycle pocket_idx=0, rom_base=0, busy=0, no result_valid. A fresh spin afterwards behaves as in the first scenario.
- With SPIN_SKIP_EN defined, skip=1 when pocket_idx=12 during cruise -> result_valid next cycle, result=12, busy=0 the following cycle.

Source files
------------

// File: rtl/roulette_spin_ctrl_if.sv
// Game-logic <-> wheel-sequencer signal bundle for roulette_spin_ctrl.
// Optional macro SPIN_SKIP_EN adds the skip request line.
interface roulette_spin_ctrl_if #(
    parameter int ADDR_W = 19
) ();
    logic              frame_tick;
    logic              spin_req;
`ifdef SPIN_SKIP_EN
    logic              skip;
`endif
    logic              busy;
    logic [5:0]        pocket_idx;
    logic [ADDR_W-1:0] rom_base;
    logic              result_valid;
    logic [5:0]        result;

`ifdef SPIN_SKIP_EN
    modport master (
        output frame_tick, spin_req, skip,
        input  busy, pocket_idx, rom_base, result_valid, result
    );
    modport slave (
        input  frame_tick, spin_req, skip,
        output busy, pocket_idx, rom_base, result_valid, result
    );
`else
    modport master (
        output frame_tick, spin_req,
        input  busy, pocket_idx, rom_base, result_valid, result
    );
    modport slave (
        input  frame_tick, spin_req,
        output busy, pocket_idx, rom_base, result_valid, result
    );
`endif
endinterface

// File: rtl/roulette_spin_ctrl.sv
// Roulette wheel animation sequencer: cruise, stepped deceleration, result report.
// Optional macro SPIN_SKIP_EN: skip input jumps straight to the result.
module roulette_spin_ctrl #(
    parameter int NUM_POCKETS    = 37,
    parameter int FRAME_PIXELS   = 4096,
    parameter int ADDR_W         = 19,
    parameter int BASE_STEPS     = 40,
    parameter int INIT_DELAY     = 1,
    parameter int MAX_DELAY      = 8,
    parameter int STEPS_PER_SLOW = 4
) (
    input  logic                  vga_clk,
    input  logic                  Reset,
    roulette_spin_ctrl_if.slave   bus
);
    localparam int DLY_W    = $clog2(MAX_DELAY + 1);
    localparam int SLOW_W   = $clog2(STEPS_PER_SLOW + 1);
    localparam int CRUISE_W = $clog2(BASE_STEPS + 64);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CRUISE,
        S_DECEL,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic [CRUISE_W-1:0] cruise_q, cruise_d;
    logic [DLY_W-1:0]    delay_q, delay_d;
    logic [DLY_W-1:0]    frame_q, frame_d;
    logic [SLOW_W-1:0]   slow_q, slow_d;
    logic [5:0]          pocket_q, pocket_d;
    logic [5:0]          result_q, result_d;
    logic [ADDR_W-1:0]   rom_base_q, rom_base_d;
    logic                busy_q, busy_d;
    logic                valid_q, valid_d;
    logic [5:0]          pocket_inc;
    logic                advance;
    logic                skip_req;

`ifdef SPIN_SKIP_EN
    assign skip_req = bus.skip;
`else
    assign skip_req = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        cruise_d   = cruise_q;
        delay_d    = delay_q;
        frame_d    = frame_q;
        slow_d     = slow_q;
        pocket_d   = pocket_q;
        pocket_inc = (pocket_q == 6'(NUM_POCKETS - 1)) ? 6'd0 : pocket_q + 6'd1;
        advance    = bus.frame_tick && (frame_q == delay_q - DLY_W'(1));

        case (state_q)
            S_IDLE: begin
                if (bus.spin_req) begin
                    state_d  = S_CRUISE;
                    cruise_d = CRUISE_W'(BASE_STEPS) + CRUISE_W'(lfsr_q[5:0]);
                    delay_d  = DLY_W'(INIT_DELAY);
                    frame_d  = '0;
                    slow_d   = '0;
                end
            end
            S_CRUISE, S_DECEL: begin
                // Skip wins over a coincident advance so the reported pocket is the one on screen.
                if (skip_req) begin
                    state_d = S_DONE;
                end else if (advance) begin
                    frame_d  = '0;
                    pocket_d = pocket_inc;
                    if (state_q == S_CRUISE) begin
                        cruise_d = cruise_q - CRUISE_W'(1);
                        if (cruise_q == CRUISE_W'(1)) begin
                            state_d = S_DECEL;
                            slow_d  = '0;
                        end
                    end else if (slow_q == SLOW_W'(STEPS_PER_SLOW - 1)) begin
                        slow_d = '0;
                        if (delay_q == DLY_W'(MAX_DELAY)) begin
                            state_d = S_DONE;
                        end else begin
                            delay_d = delay_q + DLY_W'(1);
                        end
                    end else begin
                        slow_d = slow_q + SLOW_W'(1);
                    end
                end else if (bus.frame_tick) begin
                    frame_d = frame_q + DLY_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d     = (state_d != S_IDLE);
        valid_d    = (state_d == S_DONE);
        result_d   = (state_d == S_DONE) ? pocket_d : result_q;
        // Base follows the pocket one cycle later; pocket only moves on frame_tick.
        rom_base_d = ADDR_W'(pocket_q) * ADDR_W'(FRAME_PIXELS);
    end

    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            lfsr_q     <= 16'hACE1;
            cruise_q   <= '0;
            delay_q    <= '0;
            frame_q    <= '0;
            slow_q     <= '0;
            pocket_q   <= '0;
            result_q   <= '0;
            rom_base_q <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            cruise_q   <= cruise_d;
            delay_q    <= delay_d;
            frame_q    <= frame_d;
            slow_q     <= slow_d;
            pocket_q   <= pocket_d;
            result_q   <= result_d;
            rom_base_q <= rom_base_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
        end
    end

    assign bus.busy         = busy_q;
    assign bus.pocket_idx   = pocket_q;
    assign bus.rom_base     = rom_base_q;
    assign bus.result_valid = valid_q;
    assign bus.result       = result_q;
endmodule

// File: tb/tb_roulette_spin_ctrl.sv
// Directed bench for roulette_spin_ctrl: table of spins plus wrap, abort and skip sequences.
module tb_roulette_spin_ctrl;
    logic vga_clk = 1'b0;
    logic Reset   = 1'b1;

    roulette_spin_ctrl_if #(.ADDR_W(19)) ifc ();

    roulette_spin_ctrl #(
        .NUM_POCKETS(37), .FRAME_PIXELS(4096), .ADDR_W(19), .BASE_STEPS(40),
        .INIT_DELAY(1), .MAX_DELAY(8), .STEPS_PER_SLOW(4)
    ) dut (
        .vga_clk (vga_clk),
        .Reset   (Reset),
        .bus     (ifc.slave)
    );

    always #5 vga_clk = ~vga_clk;

    // Reference LFSR straight from the polynomial, used only for the back-to-back spin.
    logic [15:0] lfsr_m;
    always @(posedge vga_clk) begin
        if (Reset) lfsr_m <= 16'hACE1;
        else       lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    end

    typedef struct {
        int wait_cyc;
        int period;
        bit mid_req;
        int exp_cruise;
        int exp_ticks;
        int exp_result;
        int exp_rom;
    } spin_vec_t;

    spin_vec_t vecs[4];
    int  n_pass  = 0;
    int  n_total = 0;
    int  iv_q[$];
    int  step_err;
    bit  wrap_seen;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic cycle();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic start_spin(input int w);
        Reset          = 1'b1;
        ifc.spin_req   = 1'b0;
        ifc.frame_tick = 1'b0;
        cycle();
        cycle();
        Reset = 1'b0;
        repeat (w) cycle();
        ifc.spin_req = 1'b1;
        cycle();
        ifc.spin_req = 1'b0;
    endtask

    // Ticks every `period` cycles until result_valid, max_adv advances, or the tick bound.
    task automatic run_spin(input int period, input bit mid_req, input int max_adv,
                            output int ticks, output int adv, output bit done);
        int since;
        int prev;
        ticks = 0; adv = 0; done = 1'b0; since = 0;
        iv_q.delete(); step_err = 0; wrap_seen = 1'b0;
        prev = int'(ifc.pocket_idx);
        while (!done && ticks < 400 && adv < max_adv) begin
            for (int k = 0; k < period - 1 && !done; k++) begin
                cycle();
                if (ifc.result_valid) done = 1'b1;
            end
            if (done) break;
            ifc.frame_tick = 1'b1;
            if (mid_req && ticks == 20) ifc.spin_req = 1'b1;
            cycle();
            ifc.frame_tick = 1'b0;
            ifc.spin_req   = 1'b0;
            ticks++;
            since++;
            if (int'(ifc.pocket_idx) != prev) begin
                if (int'(ifc.pocket_idx) != (prev + 1) % 37) step_err++;
                if (prev == 36 && ifc.pocket_idx == 6'd0) wrap_seen = 1'b1;
                iv_q.push_back(since);
                since = 0;
                adv++;
                prev = int'(ifc.pocket_idx);
            end
            if (ifc.result_valid) done = 1'b1;
        end
    endtask

    task automatic check_profile(input string name, input int cruise);
        int exp_q[$];
        int bad;
        for (int i = 0; i < cruise; i++) exp_q.push_back(1);
        for (int d = 1; d <= 8; d++)
            for (int s = 0; s < 4; s++) exp_q.push_back(d);
        bad = (iv_q.size() == exp_q.size()) ? 0 : 1;
        for (int i = 0; i < iv_q.size() && i < exp_q.size(); i++)
            if (iv_q[i] != exp_q[i]) bad++;
        check(name, bad, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int ticks, adv, exp_adv, exp_res;
        bit done;

        vecs[0] = '{wait_cyc: 1, period: 3,  mid_req: 1'b0, exp_cruise: 43, exp_ticks: 187, exp_result: 1,  exp_rom: 'h01000};
        vecs[1] = '{wait_cyc: 2, period: 5,  mid_req: 1'b0, exp_cruise: 47, exp_ticks: 191, exp_result: 5,  exp_rom: 'h05000};
        vecs[2] = '{wait_cyc: 4, period: 7,  mid_req: 1'b1, exp_cruise: 70, exp_ticks: 214, exp_result: 28, exp_rom: 'h1C000};
        vecs[3] = '{wait_cyc: 0, period: 10, mid_req: 1'b1, exp_cruise: 73, exp_ticks: 217, exp_result: 31, exp_rom: 'h1F000};

        ifc.frame_tick = 1'b0;
        ifc.spin_req   = 1'b0;
`ifdef SPIN_SKIP_EN
        ifc.skip       = 1'b0;
`endif
        Reset = 1'b1;
        repeat (3) cycle();
        Reset = 1'b0;
        check("rst_busy",   ifc.busy,         0);
        check("rst_pocket", ifc.pocket_idx,   0);
        check("rst_rom",    ifc.rom_base,     0);
        check("rst_valid",  ifc.result_valid, 0);
        check("rst_result", ifc.result,       0);

        for (int r = 0; r < 4; r++) begin
            start_spin(vecs[r].wait_cyc);
            check($sformatf("r%0d_busy_accept", r), ifc.busy, 1);
            run_spin(vecs[r].period, vecs[r].mid_req, 1000, ticks, adv, done);
            check($sformatf("r%0d_done", r),    done,  1);
            check($sformatf("r%0d_ticks", r),   ticks, vecs[r].exp_ticks);
            check($sformatf("r%0d_adv", r),     adv,   vecs[r].exp_cruise + 32);
            check($sformatf("r%0d_result", r),  ifc.result, vecs[r].exp_result);
            check($sformatf("r%0d_pocket", r),  ifc.pocket_idx, vecs[r].exp_result);
            check($sformatf("r%0d_busy_done", r), ifc.busy, 1);
            check($sformatf("r%0d_steps", r),   step_err, 0);
            check_profile($sformatf("r%0d_profile", r), vecs[r].exp_cruise);
            cycle();
            check($sformatf("r%0d_valid_pulse", r), ifc.result_valid, 0);
            check($sformatf("r%0d_busy_drop", r),   ifc.busy, 0);
            check($sformatf("r%0d_rom", r),         ifc.rom_base, vecs[r].exp_rom);
            check($sformatf("r%0d_result_hold", r), ifc.result, vecs[r].exp_result);
            $display("spin row %0d: ticks=%0d adv=%0d result=%0d rom=0x%0h", r, ticks, adv, ifc.result, ifc.rom_base);
        end

        // Back-to-back spin from pocket 31; must wrap 36 -> 0.
        check("b2b_start_pocket", ifc.pocket_idx, 31);
        exp_adv = 72 + int'(lfsr_m[5:0]);
        exp_res = (31 + exp_adv) % 37;
        ifc.spin_req = 1'b1;
        cycle();
        ifc.spin_req = 1'b0;
        run_spin(2, 1'b0, 1000, ticks, adv, done);
        check("b2b_done",   done,  1);
        check("b2b_adv",    adv,   exp_adv);
        check("b2b_ticks",  ticks, exp_adv - 32 + 144);
        check("b2b_result", ifc.result, exp_res);
        check("b2b_wrap",   wrap_seen, 1);
        check("b2b_steps",  step_err, 0);
        check_profile("b2b_profile", exp_adv - 32);
        $display("spin back-to-back: ticks=%0d adv=%0d result=%0d", ticks, adv, ifc.result);
        cycle();

        // Abort during deceleration, then a fresh spin must match the first scenario.
        start_spin(0);
        run_spin(2, 1'b0, 90, ticks, adv, done);
        check("abort_no_valid", done, 0);
        check("abort_adv",      adv,  90);
        Reset = 1'b1;
        cycle();
        check("abort_pocket", ifc.pocket_idx,   0);
        check("abort_rom",    ifc.rom_base,     0);
        check("abort_busy",   ifc.busy,         0);
        check("abort_valid",  ifc.result_valid, 0);
        check("abort_result", ifc.result,       0);
        Reset = 1'b0;
        ifc.spin_req = 1'b1;
        cycle();
        ifc.spin_req = 1'b0;
        run_spin(2, 1'b0, 1000, ticks, adv, done);
        check("fresh_done",   done,  1);
        check("fresh_ticks",  ticks, 217);
        check("fresh_result", ifc.result, 31);
        cycle();
        check("fresh_rom",    ifc.rom_base, 'h1F000);
        $display("spin after abort: ticks=%0d adv=%0d result=%0d", ticks, adv, ifc.result);

`ifdef SPIN_SKIP_EN
        start_spin(0);
        run_spin(2, 1'b0, 12, ticks, adv, done);
        check("skip_pre_pocket", ifc.pocket_idx, 12);
        ifc.skip       = 1'b1;
        ifc.frame_tick = 1'b1;
        cycle();
        ifc.skip       = 1'b0;
        ifc.frame_tick = 1'b0;
        check("skip_valid",  ifc.result_valid, 1);
        check("skip_result", ifc.result, 12);
        check("skip_pocket", ifc.pocket_idx, 12);
        cycle();
        check("skip_busy_drop", ifc.busy, 0);
        check("skip_valid_pulse", ifc.result_valid, 0);
        $display("spin skipped: result=%0d", ifc.result);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
